// File: rtl/pcap_pkg.sv
// Shared types and constants for the pcap capture-to-DMA buffer.
package pcap_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } dma_state_e;
endpackage

// File: rtl/pcap_fifo.sv
// Single-clock FIFO with registered read port (latency 1); storage array has no reset so it maps to block RAM.
module pcap_fifo #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  output logic [DW-1:0] rd_dat,
  output logic [AW:0]   level
);
  localparam int DEPTH = 2**AW;
  localparam int LW    = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  // Writes into a full FIFO are dropped even if a read happens the same cycle.
  assign do_wr = wr_en && (level != LW'(DEPTH));
  assign do_rd = rd_en && (level != '0);

  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_dat;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rd_dat <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_dat <= mem[rd_ptr];
      end
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
endmodule

// File: rtl/pcap_dma_buffer.sv
// Buffers pcap capture words and hands them to a DMA engine as fixed bursts plus a final flush.
module pcap_dma_buffer
  import pcap_pkg::*;
#(
  parameter int FIFO_AW     = 10,
  parameter int BURST_LEN   = 256,
  parameter int FULL_MARGIN = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [DATA_W-1:0] pcap_dat_i,
  input  logic              pcap_dat_valid_i,
  input  logic              pcap_done_i,
  input  logic              pcap_actv_i,
  output logic              dma_full_o,
  output logic              dma_req_o,
  output logic [FIFO_AW:0]  dma_len_o,
  output logic              dma_last_o,
  input  logic              dma_ack_i,
  input  logic              dma_rd_i,
  output logic [DATA_W-1:0] dma_dat_o,
  output logic [FIFO_AW:0]  fill_level_o,
  output logic              overflow_o
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int LW    = FIFO_AW + 1;

  dma_state_e    state;
  logic [LW-1:0] level, rd_cnt;
  logic          rd_en, actv_q, done_pending;

  assign rd_en        = dma_rd_i && (state == ST_XFER);
  assign fill_level_o = level;

  pcap_fifo #(.AW(FIFO_AW), .DW(DATA_W)) u_fifo (
    .clk    (clk_i),
    .rst_n  (reset_n_i),
    .wr_en  (pcap_dat_valid_i),
    .wr_dat (pcap_dat_i),
    .rd_en  (rd_en),
    .rd_dat (dma_dat_o),
    .level  (level)
  );

  // Back-pressure and sticky overflow; a rising pcap_actv_i re-arms overflow.
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      actv_q     <= 1'b0;
      dma_full_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      actv_q     <= pcap_actv_i;
      dma_full_o <= (level >= LW'(DEPTH - FULL_MARGIN));
      if (pcap_actv_i && !actv_q)
        overflow_o <= 1'b0;
      else if (pcap_dat_valid_i && (level == LW'(DEPTH)))
        overflow_o <= 1'b1;
    end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state        <= ST_IDLE;
      dma_req_o    <= 1'b0;
      dma_len_o    <= '0;
      dma_last_o   <= 1'b0;
      rd_cnt       <= '0;
      done_pending <= 1'b0;
    end else begin
      if (pcap_done_i) done_pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          rd_cnt <= '0;
          // Full bursts take priority; the flush only goes out once less than a burst remains.
          if (level >= LW'(BURST_LEN)) begin
            state      <= ST_REQ;
            dma_req_o  <= 1'b1;
            dma_len_o  <= LW'(BURST_LEN);
            dma_last_o <= 1'b0;
          end else if (done_pending) begin
            state      <= ST_REQ;
            dma_req_o  <= 1'b1;
            dma_len_o  <= level;
            dma_last_o <= 1'b1;
          end
        end
        ST_REQ: if (dma_ack_i) begin
          dma_req_o <= 1'b0;
          // A fresh done pulse arriving on the ack cycle belongs to the next capture.
          if (dma_last_o && !pcap_done_i) done_pending <= 1'b0;
          state <= (dma_len_o == '0) ? ST_IDLE : ST_XFER;
        end
        ST_XFER: if (dma_rd_i) begin
          rd_cnt <= rd_cnt + LW'(1);
          if (rd_cnt + LW'(1) == dma_len_o) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule
